// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - imem/dmem arbiter for one single-port memory with a response watchdog
// Optional: define ARB_ROUND_ROBIN_EN to alternate the tie-break instead of fixed dmem priority.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        arb_err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          i_vld;
    logic [31:0]   i_addr;
    logic [3:0]    i_rmask;
    logic          d_vld;
    logic [31:0]   d_addr;
    logic [3:0]    d_rmask;
    logic [3:0]    d_wmask;
    logic [31:0]   d_wdata;

    logic          pick_d, issue_i, issue_d, timeout_hit;
    logic          i_req, d_req, i_conf, d_conf;

    // A requester's transaction stops being "in flight" in its response cycle,
    // so a new request in that same cycle is accepted.
    assign i_req  = |imem_rmask;
    assign d_req  = (|dmem_rmask) || (|dmem_wmask);
    assign i_conf = i_req && (i_vld || (state == BUSY_I && !mem_resp));
    assign d_conf = d_req && (d_vld || (state == BUSY_D && !mem_resp) ||
                              ((|dmem_rmask) && (|dmem_wmask)));

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    assign pick_d = d_vld && (!i_vld || !last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (issue_d) begin
            last_d <= 1'b1;
        end else if (issue_i) begin
            last_d <= 1'b0;
        end
    end
`else
    assign pick_d = d_vld;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mem_addr    = '0;
        mem_rmask   = '0;
        mem_wmask   = '0;
        mem_wdata   = '0;
        imem_rdata  = '0;
        imem_resp   = 1'b0;
        dmem_rdata  = '0;
        dmem_resp   = 1'b0;
        issue_i     = 1'b0;
        issue_d     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    mem_addr  = d_addr;
                    mem_rmask = d_rmask;
                    mem_wmask = d_wmask;
                    mem_wdata = d_wdata;
                    issue_d   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = BUSY_D;
                end else if (i_vld) begin
                    mem_addr  = i_addr;
                    mem_rmask = i_rmask;
                    issue_i   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) begin
                    if (state == BUSY_I) begin
                        imem_resp  = 1'b1;
                        imem_rdata = mem_rdata;
                    end else begin
                        dmem_resp  = 1'b1;
                        dmem_rdata = mem_rdata;
                    end
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            i_vld   <= 1'b0;
            i_addr  <= '0;
            i_rmask <= '0;
            d_vld   <= 1'b0;
            d_addr  <= '0;
            d_rmask <= '0;
            d_wmask <= '0;
            d_wdata <= '0;
            arb_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (issue_i) begin
                i_vld <= 1'b0;
            end
            if (i_req && !i_conf) begin
                i_vld   <= 1'b1;
                i_addr  <= imem_addr;
                i_rmask <= imem_rmask;
            end
            if (issue_d) begin
                d_vld <= 1'b0;
            end
            if (d_req && !d_conf) begin
                d_vld   <= 1'b1;
                d_addr  <= dmem_addr;
                d_rmask <= dmem_rmask;
                d_wmask <= dmem_wmask;
                d_wdata <= dmem_wdata;
            end
            if (i_conf || d_conf || timeout_hit) begin
                arb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
    logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
    logic        mem_resp;
    logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        imem_resp, dmem_resp, arb_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        imem_addr  = '0;
        imem_rmask = '0;
        dmem_addr  = '0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        dmem_wdata = '0;
        mem_rdata  = '0;
        mem_resp   = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        checks++;
        if ({mem_rmask, mem_wmask, mem_addr, mem_wdata} !== 72'h0) begin
            errors++; $display("FAIL reset_mem got %h want 0", {mem_rmask, mem_wmask, mem_addr, mem_wdata});
        end
        checks++;
        if ({imem_resp, dmem_resp, imem_rdata, dmem_rdata, arb_err} !== 67'h0) begin
            errors++; $display("FAIL reset_resp got %h want 0", {imem_resp, dmem_resp, imem_rdata, dmem_rdata, arb_err});
        end
        do_reset();
    endtask

    task automatic test_single_fetch();
        do_reset();
        imem_rmask = 4'hF; imem_addr = 32'h6000_0000;
        @(negedge clk);
        checks++;
        if (mem_rmask !== 4'h0) begin errors++; $display("FAIL fetch_c0 rmask got %h want 0", mem_rmask); end
        next();
        @(negedge clk);
        checks++;
        if (mem_rmask !== 4'hF || mem_addr !== 32'h6000_0000) begin
            errors++; $display("FAIL fetch_issue got %h/%h want f/60000000", mem_rmask, mem_addr);
        end
        next();
        @(negedge clk);
        checks++;
        if (imem_resp !== 1'b0 || mem_rmask !== 4'h0) begin
            errors++; $display("FAIL fetch_c2 got resp %b rmask %h want 0/0", imem_resp, mem_rmask);
        end
        next();
        mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== 32'h13 || dmem_resp !== 1'b0 || dmem_rdata !== 32'h0) begin
            errors++; $display("FAIL fetch_resp got %b %h %b want 1 13 0", imem_resp, imem_rdata, dmem_resp);
        end
        next();
        @(negedge clk);
        checks++;
        if (imem_resp !== 1'b0 || imem_rdata !== 32'h0) begin
            errors++; $display("FAIL fetch_after got %b %h want 0 0", imem_resp, imem_rdata);
        end
    endtask

    task automatic test_simultaneous();
        logic exp_d;
        do_reset();
        imem_rmask = 4'hF; imem_addr = 32'h100;
        dmem_wmask = 4'h3; dmem_wdata = 32'hABCD; dmem_addr = 32'h200;
        next();
        @(negedge clk);
        checks++;
        if (mem_wmask !== 4'h3 || mem_rmask !== 4'h0 || mem_addr !== 32'h200 || mem_wdata !== 32'hABCD) begin
            errors++; $display("FAIL tie1_first got %h %h %h %h want 3 0 200 abcd", mem_wmask, mem_rmask, mem_addr, mem_wdata);
        end
        next();
        mem_resp = 1'b1; mem_rdata = 32'h7;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b1 || imem_resp !== 1'b0) begin
            errors++; $display("FAIL tie1_dresp got %b %b want 1 0", dmem_resp, imem_resp);
        end
        next();
        @(negedge clk);
        checks++;
        if (mem_rmask !== 4'hF || mem_addr !== 32'h100 || mem_wmask !== 4'h0) begin
            errors++; $display("FAIL tie1_second got %h %h want f 100", mem_rmask, mem_addr);
        end
        next();
        mem_resp = 1'b1;
        next();
        // a lone dmem transaction makes dmem the previous winner before the next tie
        dmem_rmask = 4'hF; dmem_addr = 32'h300;
        next();
        next();
        mem_resp = 1'b1;
        next();
        imem_rmask = 4'h1; imem_addr = 32'h104;
        dmem_rmask = 4'h2; dmem_addr = 32'h304;
        next();
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = 1'b0;
`else
        exp_d = 1'b1;
`endif
        checks++;
        if (mem_rmask !== (exp_d ? 4'h2 : 4'h1) || mem_addr !== (exp_d ? 32'h304 : 32'h104)) begin
            errors++; $display("FAIL tie2_winner got %h %h want dmem=%b", mem_rmask, mem_addr, exp_d);
        end
        next();
        mem_resp = 1'b1;
        next();
        next();
        mem_resp = 1'b1;
        next();
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_rmask = 4'hF; dmem_addr = 32'h40;
        next();
        @(negedge clk);
        checks++;
        if (mem_rmask !== 4'hF) begin errors++; $display("FAIL to_issue got %h want f", mem_rmask); end
        repeat (TO) next();
        @(negedge clk);
        checks++;
        if (arb_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", arb_err); end
        next();
        mem_resp = 1'b1; mem_rdata = 32'hDEAD;
        @(negedge clk);
        checks++;
        if (arb_err !== 1'b1 || dmem_resp !== 1'b0 || imem_resp !== 1'b0) begin
            errors++; $display("FAIL to_abort got err %b dresp %b iresp %b want 1 0 0", arb_err, dmem_resp, imem_resp);
        end
        next();
        imem_rmask = 4'hF; imem_addr = 32'h500;
        next();
        @(negedge clk);
        checks++;
        if (mem_rmask !== 4'hF || mem_addr !== 32'h500) begin
            errors++; $display("FAIL to_recover_issue got %h %h want f 500", mem_rmask, mem_addr);
        end
        next();
        mem_resp = 1'b1; mem_rdata = 32'h1234;
        @(negedge clk);
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== 32'h1234) begin
            errors++; $display("FAIL to_recover_resp got %b %h want 1 1234", imem_resp, imem_rdata);
        end
        next();
    endtask

    task automatic test_protocol_error();
        int n_issue, n_resp;
        do_reset();
        n_issue = 0; n_resp = 0;
        dmem_rmask = 4'hF; dmem_addr = 32'h80;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) begin dmem_rmask = 4'h3; dmem_addr = 32'h84; end
            if (c == 3) begin mem_resp = 1'b1; mem_rdata = 32'h55; end
            @(negedge clk);
            if (mem_rmask != 4'h0) n_issue++;
            if (dmem_resp) n_resp++;
            next();
        end
        checks++;
        if (n_issue != 1 || n_resp != 1 || arb_err !== 1'b1) begin
            errors++; $display("FAIL proto got issues %0d resps %0d err %b want 1 1 1", n_issue, n_resp, arb_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dmem_rmask = 4'hF; dmem_addr = 32'h90;
        next();
        next();
        rst = 1'b0;
        #2;
        checks++;
        if (dmem_resp !== 1'b0 || mem_rmask !== 4'h0 || arb_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_during got %b %h %b want 0 0 0", dmem_resp, mem_rmask, arb_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_resp = 1'b1; mem_rdata = 32'hBEEF;
        @(negedge clk);
        checks++;
        if (dmem_resp !== 1'b0 || imem_resp !== 1'b0 || dmem_rdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_stale got %b %b %h want 0 0 0", dmem_resp, imem_resp, dmem_rdata);
        end
        next();
        imem_rmask = 4'hF; imem_addr = 32'hA0;
        @(negedge clk);
        checks++;
        if (arb_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", arb_err); end
        next();
        @(negedge clk);
        checks++;
        if (mem_rmask !== 4'hF || mem_addr !== 32'hA0) begin
            errors++; $display("FAIL rstmid_idle got %h %h want f a0", mem_rmask, mem_addr);
        end
        next();
        mem_resp = 1'b1;
        next();
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_rmask = 4'hF; imem_addr = 32'h1000;
        next();
        next();
        mem_resp = 1'b1; mem_rdata = 32'h11;
        imem_rmask = 4'h3; imem_addr = 32'h1004;
        @(negedge clk);
        checks++;
        if (imem_resp !== 1'b1) begin errors++; $display("FAIL b2b_resp got %b want 1", imem_resp); end
        next();
        @(negedge clk);
        checks++;
        if (mem_rmask !== 4'h3 || mem_addr !== 32'h1004 || arb_err !== 1'b0) begin
            errors++; $display("FAIL b2b_issue got %h %h err %b want 3 1004 0", mem_rmask, mem_addr, arb_err);
        end
        next();
        mem_resp = 1'b1;
        next();
    endtask

    task automatic test_random();
        int owner, age, last_w, w, r;
        logic ip, dp, m_err, ireq, dreq, iconf, dconf, e_ir, e_dr;
        logic [31:0] i_a, d_a, d_wd, e_addr, e_wd;
        logic [3:0]  i_m, d_r, d_w, e_rm, e_wm;
        do_reset();
        owner = 0; age = 0; last_w = 1; ip = 0; dp = 0; m_err = 0;
        i_a = '0; d_a = '0; d_wd = '0; i_m = '0; d_r = '0; d_w = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 9) < 3) imem_rmask = 4'($urandom_range(1, 15));
            imem_addr = $urandom;
            r = $urandom_range(0, 19);
            if (r < 4) dmem_rmask = 4'($urandom_range(1, 15));
            else if (r < 8) dmem_wmask = 4'($urandom_range(1, 15));
            else if (r == 8) begin dmem_rmask = 4'hF; dmem_wmask = 4'h1; end
            dmem_addr  = $urandom & 32'hFFFF_FFFC;
            dmem_wdata = $urandom;
            mem_resp   = ($urandom_range(0, 9) < 4);
            mem_rdata  = $urandom;
            @(negedge clk);
            w = 0;
            if (owner == 0 && (ip || dp)) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (ip && dp) w = (last_w == 2) ? 1 : 2;
                else w = dp ? 2 : 1;
`else
                w = dp ? 2 : 1;
`endif
            end
            e_addr = (w == 2) ? d_a : (w == 1) ? i_a : 32'h0;
            e_rm   = (w == 2) ? d_r : (w == 1) ? i_m : 4'h0;
            e_wm   = (w == 2) ? d_w : 4'h0;
            e_wd   = (w == 2) ? d_wd : 32'h0;
            e_ir   = (owner == 1) && mem_resp;
            e_dr   = (owner == 2) && mem_resp;
            checks++;
            if (mem_addr !== e_addr || mem_rmask !== e_rm || mem_wmask !== e_wm || mem_wdata !== e_wd) begin
                errors++; $display("FAIL rnd_mem cyc %0d got %h %h %h %h want %h %h %h %h",
                                   cyc, mem_addr, mem_rmask, mem_wmask, mem_wdata, e_addr, e_rm, e_wm, e_wd);
            end
            checks++;
            if (imem_resp !== e_ir || imem_rdata !== (e_ir ? mem_rdata : 32'h0)) begin
                errors++; $display("FAIL rnd_imem cyc %0d got %b %h want %b", cyc, imem_resp, imem_rdata, e_ir);
            end
            checks++;
            if (dmem_resp !== e_dr || dmem_rdata !== (e_dr ? mem_rdata : 32'h0)) begin
                errors++; $display("FAIL rnd_dmem cyc %0d got %b %h want %b", cyc, dmem_resp, dmem_rdata, e_dr);
            end
            checks++;
            if (arb_err !== m_err) begin
                errors++; $display("FAIL rnd_err cyc %0d got %b want %b", cyc, arb_err, m_err);
            end
            ireq  = (imem_rmask != 0);
            dreq  = (dmem_rmask != 0) || (dmem_wmask != 0);
            iconf = ireq && (ip || (owner == 1 && !mem_resp));
            dconf = dreq && (dp || (owner == 2 && !mem_resp) || (dmem_rmask != 0 && dmem_wmask != 0));
            if (w != 0) begin
                owner = w; age = 0; last_w = w;
                if (w == 1) ip = 0; else dp = 0;
            end else if (owner != 0) begin
                if (mem_resp) owner = 0;
                else begin
                    age++;
                    if (age == TO) begin m_err = 1; owner = 0; end
                end
            end
            if (iconf || dconf) m_err = 1;
            if (ireq && !iconf) begin ip = 1; i_a = imem_addr; i_m = imem_rmask; end
            if (dreq && !dconf) begin
                dp = 1; d_a = dmem_addr; d_r = dmem_rmask; d_w = dmem_wmask; d_wd = dmem_wdata;
            end
            // restart from a clean error flag now and then so late-run errors stay observable
            if (cyc % 150 == 149) begin
                do_reset();
                owner = 0; age = 0; last_w = 1; ip = 0; dp = 0; m_err = 0;
            end else begin
                next();
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_timeout();
        test_protocol_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port memory between instruction fetch (imem) and the execute stage's data access (dmem). It captures each requester's one-cycle request, issues one transaction at a time to the memory port, and routes `mem_rdata` and `mem_resp` back to the requester that owns the transaction. It sits between the fetch/ex stages and the memory model or cache, and adds a response-timeout watchdog.

## Interface
- `TIMEOUT`, 255: maximum number of busy cycles to wait for `mem_resp` before the transaction is aborted; must be ≥1.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_addr` / `imem_rmask`  in  32 / 4  fetch request; a nonzero `imem_rmask` for one cycle is one read request.
- `imem_rdata` / `imem_resp`  out  32 / 1  fetch response; `imem_resp` pulses for one cycle.
- `dmem_addr` / `dmem_rmask` / `dmem_wmask` / `dmem_wdata`  in  32 / 4 / 4 / 32  data request; a nonzero mask for one cycle is one request. `dmem_addr` is word-aligned.
- `dmem_rdata` / `dmem_resp`  out  32 / 1  data response; `dmem_resp` pulses for one cycle.
- `mem_addr` / `mem_rmask` / `mem_wmask` / `mem_wdata`  out  32 / 4 / 4 / 32  memory request; masks are nonzero for exactly one cycle per transaction.
- `mem_rdata` / `mem_resp`  in  32 / 1  memory response.
- `arb_err`  out  1  sticky error flag; cleared only by reset.

## Operation
- Each requester has one pending slot holding addr, masks and wdata. A request is captured on the edge where its mask is nonzero.
- **Capture conflicts** (request ignored, `arb_err` set):
  - a new request arrives while that requester's slot is occupied or its transaction is in flight;
  - `dmem_rmask` and `dmem_wmask` are both nonzero.
- **State machine:**
  - IDLE: no pending slot → stay. Otherwise select one slot, drive the `mem_*` outputs from it for that cycle, clear the slot, load the timeout counter with 0, and go to BUSY_I or BUSY_D.
  - BUSY_x on `mem_resp`: drive `x_resp`=1 and `x_rdata`=`mem_rdata` combinationally in the same cycle, then go to IDLE.
  - BUSY_x without `mem_resp`: increment the counter. When the counter reaches TIMEOUT−1, set `arb_err`, drop the transaction (no `x_resp`) and go to IDLE.
- **Selection:** dmem wins when both slots are pending (see Configuration).
- `mem_resp` while in IDLE (for example after a reset mid-transaction) is dropped and not forwarded; `arb_err` is unaffected.
- A requester may present a new request in the same cycle its `x_resp` pulses. It is captured normally, because the slot frees on issue.
- Outputs default to zero: `mem_*`=0 outside issue cycles and `*_rdata`=0 when the matching resp=0.

## Timing
- **Reset values:** state IDLE, slots empty, counter 0, `arb_err`=0, all outputs 0.
- A reset assertion in the middle of a transaction aborts it immediately; no response is produced.
- **Latency:** request seen at cycle 0 → captured at the end of 0 → `mem_*` issue in cycle 1 → response in cycle k = cycle of `mem_resp` → next issue no earlier than k+1.
- Back-to-back throughput is at best one transaction per 2 cycles: issue, resp, issue, …
- The counter is $clog2(TIMEOUT+1) bits and never wraps; it is reloaded on every issue.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both slots are pending, the winner is the requester that did not win the previous issue. The last-winner register resets to imem, so dmem wins the first tie.
- Undefined: fixed priority, dmem always wins ties. imem may starve under continuous dmem traffic; this is the intended behaviour for the in-order pipeline.

## Test plan
- Single fetch: `imem_rmask`=F, addr 0x6000_0000 at cycle 0; `mem_resp`, rdata 0x0000_0013 at cycle 3 → `mem_rmask`=F in cycle 1, `imem_resp`=1 and `imem_rdata`=0x13 in cycle 3, `dmem_resp` stays 0.
- Simultaneous requests: imem read 0x100 and dmem write `wmask`=3, `wdata`=0xABCD to 0x200 in cycle 0; memory responds 1 cycle after each issue → fixed priority: dmem issue cycle 1, imem issue cycle 3. Round-robin after reset: same order, and on a second tie imem issues first.
- Timeout: TIMEOUT=4, dmem read, no `mem_resp` → `arb_err` rises 4 cycles after issue, no `dmem_resp`. A late `mem_resp` afterwards is ignored, and a following imem request completes normally.
- Protocol error: second `dmem_rmask` while dmem is in flight → `arb_err`=1; only one `mem_*` issue and one `dmem_resp` occur.
- Reset mid-transaction: assert `rst`=0 in BUSY_D, release, then pulse `mem_resp` → no `dmem_resp`, `arb_err`=0, state IDLE.
- Pipelined reuse: imem issues its next request in its own resp cycle → the next `mem_rmask` issues exactly one cycle later.
